// File: rtl/game_pkg.sv
// Shared types and constants for the note-block play pipeline.
// Song time is an 18-bit count of 10 ms units.
package game_pkg;

  localparam int TIME_W  = 18;
  localparam int FF_STEP = 4;

  typedef enum logic [2:0] {IDLE, LOAD, PLAY, PAUSE, DONE} seq_state_t;

  // Unsigned add clamped to lim, computed one bit wider so it cannot wrap.
  function automatic logic [TIME_W-1:0] sat_add(input logic [TIME_W-1:0] a,
                                                input logic [TIME_W-1:0] b,
                                                input logic [TIME_W-1:0] lim);
    logic [TIME_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum >= {1'b0, lim}) ? lim : sum[TIME_W-1:0];
  endfunction

endpackage

// File: rtl/song_sequencer_if.sv
// Control pulses in and song time / status out; the sequencer uses the slave view.
// ff_in exists only when FAST_FORWARD_EN is defined.
interface song_sequencer_if;

  logic                       start_in;
  logic                       pause_in;
  logic                       restart_in;
`ifdef FAST_FORWARD_EN
  logic                       ff_in;
`endif
  logic [game_pkg::TIME_W-1:0] curr_time_out;
  logic                       tick_out;
  logic                       loader_rst_out;
  logic                       playing_out;
  logic                       song_done_out;

`ifdef FAST_FORWARD_EN
  modport master (output start_in, pause_in, restart_in, ff_in,
                  input  curr_time_out, tick_out, loader_rst_out, playing_out, song_done_out);
  modport slave  (input  start_in, pause_in, restart_in, ff_in,
                  output curr_time_out, tick_out, loader_rst_out, playing_out, song_done_out);
`else
  modport master (output start_in, pause_in, restart_in,
                  input  curr_time_out, tick_out, loader_rst_out, playing_out, song_done_out);
  modport slave  (input  start_in, pause_in, restart_in,
                  output curr_time_out, tick_out, loader_rst_out, playing_out, song_done_out);
`endif

endinterface

// File: rtl/tick_prescaler.sv
// Divides the clock down to one wrap per CYCLES_PER_TICK enabled cycles.
// wrap_out is combinational on the last count; holding en_in low freezes the count.
module tick_prescaler #(
  parameter int CYCLES_PER_TICK = 742_500
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clear_in,
  input  logic en_in,
  output logic wrap_out
);

  localparam int            CW   = $clog2(CYCLES_PER_TICK);
  localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_TICK - 1);

  logic [CW-1:0] count;

  assign wrap_out = en_in && (count == LAST);

  always_ff @(posedge clk_in) begin
    if (rst_in || clear_in) begin
      count <= '0;
    end else if (en_in) begin
      count <= wrap_out ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// Play controller: owns song time, sequences loader reset/preload, pause, restart, end.
// All outputs registered; an input pulse takes effect the next cycle. FAST_FORWARD_EN adds ff_in.
module song_sequencer
  import game_pkg::*;
#(
  parameter int                CYCLES_PER_TICK = 742_500,
  parameter int                PRELOAD_CYCLES  = 16,
  parameter logic [TIME_W-1:0] SONG_END_TIME   = 18'd400
) (
  input  logic            clk_in,
  input  logic            rst_in,
  song_sequencer_if.slave bus
);

  localparam int            PW      = $clog2(PRELOAD_CYCLES);
  localparam logic [PW-1:0] PL_LAST = PW'(PRELOAD_CYCLES - 1);

  seq_state_t        state;
  seq_state_t        next_state;
  logic [TIME_W-1:0] curr_time;
  logic [TIME_W-1:0] time_next;
  logic [TIME_W-1:0] step;
  logic [PW-1:0]     preload;
  logic              enter_load;
  logic              run;
  logic              wrap;
  logic              tick;
  logic              tick_next;
  logic              loader_rst;
  logic              playing;
  logic              done;

  // Prescaler only advances on PLAY cycles that are not being pre-empted.
  assign run = (state == PLAY) && !bus.restart_in && !bus.pause_in;

`ifdef FAST_FORWARD_EN
  assign step = bus.ff_in ? TIME_W'(FF_STEP) : TIME_W'(1);
`else
  assign step = TIME_W'(1);
`endif

  tick_prescaler #(
    .CYCLES_PER_TICK(CYCLES_PER_TICK)
  ) u_prescaler (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .clear_in (enter_load),
    .en_in    (run),
    .wrap_out (wrap)
  );

  always_comb begin
    next_state = state;
    enter_load = 1'b0;
    tick_next  = 1'b0;
    time_next  = curr_time;
    unique case (state)
      IDLE: begin
        if (bus.start_in) enter_load = 1'b1;
      end
      LOAD: begin
        if (bus.restart_in)          enter_load = 1'b1;
        else if (preload == PL_LAST) next_state = PLAY;
      end
      PLAY: begin
        if (bus.restart_in) begin
          enter_load = 1'b1;
        end else if (bus.pause_in) begin
          next_state = PAUSE;
        end else if (wrap) begin
          tick_next = 1'b1;
          time_next = sat_add(curr_time, step, SONG_END_TIME);
          if (time_next == SONG_END_TIME) next_state = DONE;
        end
      end
      PAUSE: begin
        if (bus.restart_in)    enter_load = 1'b1;
        else if (bus.start_in) next_state = PLAY;
      end
      DONE: begin
        if (bus.restart_in || bus.start_in) enter_load = 1'b1;
      end
      default: next_state = IDLE;
    endcase
    if (enter_load) begin
      next_state = LOAD;
      time_next  = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= IDLE;
      curr_time  <= '0;
      tick       <= 1'b0;
      loader_rst <= 1'b1;
      preload    <= '0;
      playing    <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= next_state;
      curr_time  <= time_next;
      tick       <= tick_next;
      loader_rst <= enter_load || (next_state == IDLE);
      preload    <= (next_state == LOAD && !enter_load) ? preload + 1'b1 : '0;
      playing    <= (next_state == PLAY);
      done       <= (next_state == DONE);
    end
  end

  assign bus.curr_time_out  = curr_time;
  assign bus.tick_out       = tick;
  assign bus.loader_rst_out = loader_rst;
  assign bus.playing_out    = playing;
  assign bus.song_done_out  = done;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: directed scenarios plus random pulses against a behavioural model.
// Build with FAST_FORWARD_EN defined to also cover fast-forward.
module tb_song_sequencer;
  import game_pkg::*;

  localparam int CPT   = 4;
  localparam int PRE   = 14;
  localparam int END_T = 10;

  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_PLAY  = 2;
  localparam int M_PAUSE = 3;
  localparam int M_DONE  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  song_sequencer_if bus ();

  song_sequencer #(
    .CYCLES_PER_TICK (CPT),
    .PRELOAD_CYCLES  (PRE),
    .SONG_END_TIME   (18'(END_T))
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int ticks    = 0;
  bit ff_lvl   = 1'b0;

  // Reference model: mode, song time, cycles elapsed in the current tick, cycles spent in LOAD.
  int m_mode  = M_IDLE;
  int m_time  = 0;
  int m_phase = 0;
  int m_age   = 0;
  int m_tick  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_load();
    m_mode  = M_LOAD;
    m_age   = 0;
    m_time  = 0;
    m_phase = 0;
  endtask

  task automatic model_step(input bit s, input bit p, input bit r, input bit f, input bit x);
    int inc;
    inc    = 1;
`ifdef FAST_FORWARD_EN
    if (f) inc = FF_STEP;
`endif
    m_tick = 0;
    if (x) begin
      m_mode = M_IDLE; m_time = 0; m_phase = 0; m_age = 0;
    end else begin
      case (m_mode)
        M_IDLE:  if (s) model_load();
        M_LOAD:  if (r) model_load();
                 else if (m_age == PRE - 1) begin m_mode = M_PLAY; m_phase = 0; end
                 else m_age++;
        M_PLAY:  if (r) model_load();
                 else if (p) m_mode = M_PAUSE;
                 else if (m_phase == CPT - 1) begin
                   m_phase = 0;
                   m_time  = (m_time + inc > END_T) ? END_T : m_time + inc;
                   m_tick  = 1;
                   if (m_time == END_T) m_mode = M_DONE;
                 end else m_phase++;
        M_PAUSE: if (r) model_load();
                 else if (s) m_mode = M_PLAY;
        default: if (r || s) model_load();
      endcase
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, compare every output 1 time unit later.
  task automatic step(input bit s, input bit p, input bit r, input bit x);
    bus.start_in   = s;
    bus.pause_in   = p;
    bus.restart_in = r;
`ifdef FAST_FORWARD_EN
    bus.ff_in      = ff_lvl;
`endif
    rst = x;
    @(posedge clk);
    model_step(s, p, r, ff_lvl, x);
    #1;
    if (bus.tick_out) ticks++;
    check("m_time", int'(bus.curr_time_out), m_time);
    check("m_tick", int'(bus.tick_out), m_tick);
    check("m_ldr",  int'(bus.loader_rst_out),
          int'(m_mode == M_IDLE || (m_mode == M_LOAD && m_age == 0)));
    check("m_play", int'(bus.playing_out), int'(m_mode == M_PLAY));
    check("m_done", int'(bus.song_done_out), int'(m_mode == M_DONE));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  initial begin
    bus.start_in   = 1'b0;
    bus.pause_in   = 1'b0;
    bus.restart_in = 1'b0;
`ifdef FAST_FORWARD_EN
    bus.ff_in      = 1'b0;
`endif
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    idle(3);
    check("rst_time", int'(bus.curr_time_out), 0);
    check("rst_ldr",  int'(bus.loader_rst_out), 1);
    check("rst_play", int'(bus.playing_out), 0);
    check("rst_done", int'(bus.song_done_out), 0);

    // Start at cycle N: loader reset through N+1, PLAY at N+15, first tick at N+19.
    step(1, 0, 0, 0);
    check("st_ldr_n1", int'(bus.loader_rst_out), 1);
    step(0, 0, 0, 0);
    check("st_ldr_n2", int'(bus.loader_rst_out), 0);
    idle(12);
    check("st_play_n14", int'(bus.playing_out), 0);
    step(0, 0, 0, 0);
    check("st_play_n15", int'(bus.playing_out), 1);
    idle(3);
    check("st_time_n18", int'(bus.curr_time_out), 0);
    step(0, 0, 0, 0);
    check("st_time_n19", int'(bus.curr_time_out), 1);
    check("st_tick_n19", int'(bus.tick_out), 1);

    // Pause on the wrap cycle that would take time 3 -> 4.
    idle(8);
    check("pw_time3", int'(bus.curr_time_out), 3);
    idle(3);
    step(0, 1, 0, 0);
    check("pw_time", int'(bus.curr_time_out), 3);
    check("pw_tick", int'(bus.tick_out), 0);
    check("pw_play", int'(bus.playing_out), 0);
    ticks = 0;
    idle(20);
    check("pw_hold_ticks", ticks, 0);
    check("pw_hold_time", int'(bus.curr_time_out), 3);
    step(1, 0, 0, 0);
    check("res_play", int'(bus.playing_out), 1);
    step(0, 0, 0, 0);
    check("res_time4", int'(bus.curr_time_out), 4);
    check("res_tick", int'(bus.tick_out), 1);

    // Restart from PAUSE at time 6.
    for (int i = 0; i < 50 && bus.curr_time_out != 18'd6; i++) step(0, 0, 0, 0);
    check("rs_reach6", int'(bus.curr_time_out), 6);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    check("rs_time", int'(bus.curr_time_out), 0);
    check("rs_ldr1", int'(bus.loader_rst_out), 1);
    step(0, 0, 0, 0);
    check("rs_ldr2", int'(bus.loader_rst_out), 0);
    idle(12);
    check("rs_play14", int'(bus.playing_out), 0);
    step(0, 0, 0, 0);
    check("rs_play15", int'(bus.playing_out), 1);

    // Play to the end, then start again.
    for (int i = 0; i < 200 && !bus.song_done_out; i++) step(0, 0, 0, 0);
    check("end_done", int'(bus.song_done_out), 1);
    check("end_time", int'(bus.curr_time_out), END_T);
    check("end_tick", int'(bus.tick_out), 1);
    check("end_play", int'(bus.playing_out), 0);
    ticks = 0;
    idle(10);
    check("end_noticks", ticks, 0);
    check("end_hold", int'(bus.curr_time_out), END_T);
    step(1, 0, 0, 0);
    check("again_time", int'(bus.curr_time_out), 0);
    check("again_ldr1", int'(bus.loader_rst_out), 1);
    check("again_done", int'(bus.song_done_out), 0);
    step(0, 0, 0, 0);
    check("again_ldr2", int'(bus.loader_rst_out), 0);

    // Reset mid-LOAD, then restart+pause together while playing.
    idle(3);
    step(0, 0, 0, 1);
    check("ml_ldr", int'(bus.loader_rst_out), 1);
    check("ml_play", int'(bus.playing_out), 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 40 && !bus.playing_out; i++) step(0, 0, 0, 0);
    idle(2);
    step(0, 1, 1, 0);
    check("rp_ldr", int'(bus.loader_rst_out), 1);
    check("rp_play", int'(bus.playing_out), 0);
    check("rp_time", int'(bus.curr_time_out), 0);

`ifdef FAST_FORWARD_EN
    begin
      int seen[$];
      ff_lvl = 1'b1;
      for (int i = 0; i < 200 && !bus.song_done_out; i++) begin
        step(0, 0, 0, 0);
        if (bus.tick_out) seen.push_back(int'(bus.curr_time_out));
      end
      check("ff_count", seen.size(), 3);
      check("ff_done", int'(bus.song_done_out), 1);
      if (seen.size() == 3) begin
        check("ff_t0", seen[0], 4);
        check("ff_t1", seen[1], 8);
        check("ff_t2", seen[2], END_T);
      end
      step(0, 0, 1, 0);
    end
`endif

    // Random pulse traffic checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      ff_lvl = ($urandom_range(0, 3) != 0);
      step($urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 59) == 0, $urandom_range(0, 299) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/song_sequencer.md
# song_sequencer

Top-level play controller for the note-block pipeline: owns the song clock (`curr_time`, 10 ms units), holds the block loader in reset until play is requested, and releases it with a fixed preload window so its 12-entry buffer is full before time starts advancing. It also handles pause, resume, restart and end-of-song. It sits between the user-input debouncers and the block loader/renderer chain, and is the sole source of `curr_time` for that chain.

## Interface
Parameters:
- `CYCLES_PER_TICK`, default 742_500: clock cycles per time unit (10 ms at 74.25 MHz); must be ≥ 2.
- `PRELOAD_CYCLES`, default 16: cycles between loader release and first time advance; must be ≥ 14.
- `SONG_END_TIME`, default 18'd400: time value at which the song ends.

Ports (one clock; reset is synchronous and active-high):
- `clk_in`  input  1  system clock
- `rst_in`  input  1  synchronous active-high reset
- `start_in`  input  1  one-cycle pulse: start from IDLE/DONE, resume from PAUSE
- `pause_in`  input  1  one-cycle pulse: pause while in PLAY
- `restart_in`  input  1  one-cycle pulse: reload and replay from time 0
- `ff_in`  input  1  fast-forward hold; present only with `FAST_FORWARD_EN`
- `curr_time_out`  output  18  song time; feeds the loader's time input
- `tick_out`  output  1  one-cycle pulse on each `curr_time_out` update
- `loader_rst_out`  output  1  reset to the block loader
- `playing_out`  output  1  high in PLAY
- `song_done_out`  output  1  high in DONE

## Operation
- States:
  - IDLE, LOAD, PLAY, PAUSE, DONE.
  - `rst_in` forces IDLE from any state, mid-LOAD or mid-tick included.
- Reset and IDLE outputs:
  - `curr_time_out`=0, `tick_out`=0, `loader_rst_out`=1, `playing_out`=0, `song_done_out`=0.
  - Prescaler and preload counters = 0.
- IDLE: `start_in` → LOAD.
- LOAD:
  - `loader_rst_out` is high in the first LOAD cycle only, then low.
  - `curr_time_out` = 0; preload counter counts up.
  - When the counter reaches `PRELOAD_CYCLES`-1 → PLAY with the prescaler at 0.
- PLAY:
  - The prescaler counts 0..`CYCLES_PER_TICK`-1, then wraps.
  - On wrap, `curr_time_out` += 1 (saturating at `SONG_END_TIME`) and `tick_out` pulses.
  - When the updated value equals `SONG_END_TIME` → DONE.
- PAUSE:
  - Prescaler and time are frozen.
  - `start_in` → PLAY, continuing from the frozen prescaler value.
- DONE:
  - `curr_time_out` holds `SONG_END_TIME`.
  - `start_in` → LOAD, with time cleared to 0.
- `restart_in`:
  - In LOAD/PLAY/PAUSE/DONE: → LOAD. Time, prescaler and preload counter are cleared; a fresh one-cycle `loader_rst_out` is issued.
  - Ignored in IDLE.
- Priority when inputs coincide: `rst_in` > `restart_in` > `pause_in` > `start_in` > prescaler wrap.
  - `pause_in` on a wrap cycle: no increment, no `tick_out`; the prescaler holds at `CYCLES_PER_TICK`-1, so the increment occurs on the first cycle after resume.
- `pause_in` outside PLAY is ignored. `start_in` in LOAD or PLAY is ignored.
- Arithmetic: 18-bit unsigned with saturating add. `curr_time_out` never exceeds `SONG_END_TIME`.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- An input pulse in cycle N changes state and outputs in cycle N+1.
- `start_in` in IDLE at cycle N:
  - `loader_rst_out` is high in cycles N..N+1 (IDLE plus first LOAD cycle) and low from N+2.
  - `playing_out` rises at N+1+`PRELOAD_CYCLES`.
- First `tick_out` (time becomes 1) comes `CYCLES_PER_TICK` cycles after `playing_out` rises.
- `tick_out` and the new `curr_time_out` value appear in the same cycle.
- `song_done_out` rises in the same cycle as the final `tick_out`; `playing_out` falls in that cycle.

## Configuration
- `FAST_FORWARD_EN` defined:
  - `ff_in` port exists.
  - While `ff_in`=1 in PLAY, each wrap adds 4 instead of 1, still saturating at `SONG_END_TIME`; the DONE transition is unchanged.
  - `ff_in` has no effect outside PLAY.
- Not defined: the port is absent and the increment is always 1.

## Structure
- Shared package `game_pkg`:
  - `TIME_W`=18.
  - `seq_state_t` enum {IDLE, LOAD, PLAY, PAUSE, DONE}.
  - `FF_STEP`=4.
- Sub-module `tick_prescaler`:
  - Ports: `clk_in`, `rst_in`, `clear_in`, `en_in`; output `wrap_out`.
  - Parameter: `CYCLES_PER_TICK`.
  - The parent FSM drives `en_in` only in PLAY and `clear_in` on LOAD entry.

## Test plan
Benches use `CYCLES_PER_TICK`=4, `PRELOAD_CYCLES`=14, `SONG_END_TIME`=10.
- Reset then `start_in` at cycle 5 → `loader_rst_out` low from cycle 7; `playing_out` high at cycle 20; `curr_time_out`=1 with `tick_out` at cycle 24.
- Play to end → `curr_time_out` reaches 10, `song_done_out`=1, no further ticks; `start_in` → LOAD, time 0, single `loader_rst_out` pulse.
- `pause_in` on a wrap cycle at time 3 → time stays 3, no `tick_out`; `start_in` after 20 idle cycles → time 4 on the next cycle.
- `restart_in` at time 6 in PAUSE → LOAD, time 0, one `loader_rst_out` pulse; `playing_out` returns after 14 cycles.
- `rst_in` mid-LOAD, and `restart_in`+`pause_in` in the same cycle → IDLE reset values / LOAD respectively.
- `FAST_FORWARD_EN`: `ff_in`=1 from time 0 → times 4, 8, 10 (saturated), then DONE.
